// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the FPG8 control sequencer: FSM state encoding, opcodes
// and small decode helpers used by the sequencer and its wait timer.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_DEC,
    ST_EX_ALU,
    ST_EX_MOV,
    ST_L0,
    ST_L1,
    ST_L2,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_EX_JMP,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_MOV   = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BRZ   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // 1010..1110 are unassigned; they retire as NOPs but raise the sticky flag.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'hA) && (op != OP_HALT);
  endfunction

  function automatic logic is_wait_state(input state_t st);
    return (st == ST_F1) || (st == ST_L1) || (st == ST_S2);
  endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Memory wait timer: counts cycles spent in a memory wait state and flags
// expiry once MAX cycles have elapsed without the access completing.
module control_sequencer_mem_wait_timer
  import control_sequencer_pkg::*;
#(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] count;

  // Count holds at MAX-1 so expiry stays asserted until the timer is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(MAX - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the FPG8 datapath; drives the one-hot
// bus strobes from the state register and tracks halt/fault/illegal status.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [3:0]       opcode,
  input  logic             S,
  input  logic             zero_flag,
  output logic             PC_out,
  output logic             PC_in,
  output logic             PC_inc,
  output logic             MAR_in,
  output logic             MDR_out,
  output logic             MDR_in,
  output logic             IR_in,
  output logic             RS_out,
  output logic             RD_out,
  output logic             RD_in,
  output logic             ALU_out,
  output logic             FLAGS_in,
  output logic             MEM_rd,
  output logic             MEM_wr,
  output logic [2:0]       ALU_op,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state;
  state_t           state_next;
  logic [2:0]       alu_op_q;
  logic             flags_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             in_wait;
  logic             wait_expired;

  assign in_wait = is_wait_state(state);

  // Cleared whenever we are outside a wait state, so every access starts from zero.
  control_sequencer_mem_wait_timer #(
    .MAX(MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ALU function and set-flags bit are captured at decode so the execute strobes
  // depend only on registered state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_op_q  <= 3'b000;
      flags_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (state == ST_DEC) begin
        alu_op_q <= opcode[2:0];
        flags_q  <= S;
        if (is_illegal_op(opcode)) begin
          illegal_q <= 1'b1;
        end
      end
      if (state == ST_F2) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (run) state_next = ST_F0;
      ST_F0:     state_next = ST_F1;
      ST_F1: begin
        if (mem_ready)         state_next = ST_F2;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_F2:     state_next = ST_DEC;
      ST_DEC: begin
        if (is_alu_op(opcode)) begin
          state_next = ST_EX_ALU;
        end else begin
          case (opcode)
            OP_MOV:   state_next = ST_EX_MOV;
            OP_LOAD:  state_next = ST_L0;
            OP_STORE: state_next = ST_S0;
            OP_JMP:   state_next = ST_EX_JMP;
            OP_BRZ:   state_next = zero_flag ? ST_EX_JMP : ST_F0;
            OP_HALT:  state_next = ST_HALT;
            default:  state_next = ST_F0;
          endcase
        end
      end
      ST_EX_ALU: state_next = ST_F0;
      ST_EX_MOV: state_next = ST_F0;
      ST_EX_JMP: state_next = ST_F0;
      ST_L0:     state_next = ST_L1;
      ST_L1: begin
        if (mem_ready)         state_next = ST_L2;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_L2:     state_next = ST_F0;
      ST_S0:     state_next = ST_S1;
      ST_S1:     state_next = ST_S2;
      ST_S2: begin
        if (mem_ready)         state_next = ST_F0;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_HALT:   state_next = ST_HALT;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    PC_out   = 1'b0;
    PC_in    = 1'b0;
    PC_inc   = 1'b0;
    MAR_in   = 1'b0;
    MDR_out  = 1'b0;
    MDR_in   = 1'b0;
    IR_in    = 1'b0;
    RS_out   = 1'b0;
    RD_out   = 1'b0;
    RD_in    = 1'b0;
    ALU_out  = 1'b0;
    FLAGS_in = 1'b0;
    MEM_rd   = 1'b0;
    MEM_wr   = 1'b0;
    ALU_op   = 3'b000;
    unique case (state)
      ST_F0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
      end
      ST_F1:     MEM_rd = 1'b1;
      ST_F2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
        PC_inc  = 1'b1;
      end
      ST_EX_ALU: begin
        RS_out   = 1'b1;
        ALU_out  = 1'b1;
        RD_in    = 1'b1;
        ALU_op   = alu_op_q;
        FLAGS_in = flags_q;
      end
      ST_EX_MOV: begin
        RS_out = 1'b1;
        RD_in  = 1'b1;
      end
      ST_EX_JMP: begin
        RS_out = 1'b1;
        PC_in  = 1'b1;
      end
      ST_L0: begin
        RS_out = 1'b1;
        MAR_in = 1'b1;
      end
      ST_L1:     MEM_rd = 1'b1;
      ST_L2: begin
        MDR_out = 1'b1;
        RD_in   = 1'b1;
      end
      ST_S0: begin
        RS_out = 1'b1;
        MAR_in = 1'b1;
      end
      ST_S1: begin
        RD_out = 1'b1;
        MDR_in = 1'b1;
      end
      ST_S2:     MEM_wr = 1'b1;
      default: begin
      end
    endcase
  end

  assign halted      = (state == ST_HALT);
  assign fault       = (state == ST_FAULT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: builds the expected per-cycle strobe sequence of each instruction
// from the ISA timing rules, plays it open-loop against the sequencer and compares.
module tb_control_sequencer;

  localparam int MEM_WAIT_MAX = 16;

  localparam logic [19:0] V_PC_OUT   = 20'h80000;
  localparam logic [19:0] V_PC_IN    = 20'h40000;
  localparam logic [19:0] V_PC_INC   = 20'h20000;
  localparam logic [19:0] V_MAR_IN   = 20'h10000;
  localparam logic [19:0] V_MDR_OUT  = 20'h08000;
  localparam logic [19:0] V_MDR_IN   = 20'h04000;
  localparam logic [19:0] V_IR_IN    = 20'h02000;
  localparam logic [19:0] V_RS_OUT   = 20'h01000;
  localparam logic [19:0] V_RD_OUT   = 20'h00800;
  localparam logic [19:0] V_RD_IN    = 20'h00400;
  localparam logic [19:0] V_ALU_OUT  = 20'h00200;
  localparam logic [19:0] V_FLAGS_IN = 20'h00100;
  localparam logic [19:0] V_MEM_RD   = 20'h00080;
  localparam logic [19:0] V_MEM_WR   = 20'h00040;
  localparam logic [19:0] V_HALTED   = 20'h00004;
  localparam logic [19:0] V_FAULT    = 20'h00002;
  localparam logic [19:0] V_ILLEGAL  = 20'h00001;

  typedef struct {
    logic        run;
    logic        mr;
    logic [3:0]  op;
    logic        s;
    logic        z;
    logic [19:0] vec;
    logic [15:0] cnt;
  } row_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        S = 1'b0;
  logic        zero_flag = 1'b0;
  logic        PC_out, PC_in, PC_inc, MAR_in, MDR_out, MDR_in, IR_in;
  logic        RS_out, RD_out, RD_in, ALU_out, FLAGS_in, MEM_rd, MEM_wr;
  logic [2:0]  ALU_op;
  logic        halted, fault, illegal;
  logic [15:0] instr_count;
  logic [19:0] obs;

  int          checks = 0;
  int          passes = 0;
  row_t        rows[$];
  logic [19:0] seen[$];
  logic [15:0] seen_cnt[$];
  logic [15:0] m_cnt;
  logic        m_ill, m_halt, m_fault;
  logic [3:0]  cur_op;
  logic        cur_s;

  control_sequencer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem_ready  (mem_ready),
    .opcode     (opcode),
    .S          (S),
    .zero_flag  (zero_flag),
    .PC_out     (PC_out),
    .PC_in      (PC_in),
    .PC_inc     (PC_inc),
    .MAR_in     (MAR_in),
    .MDR_out    (MDR_out),
    .MDR_in     (MDR_in),
    .IR_in      (IR_in),
    .RS_out     (RS_out),
    .RD_out     (RD_out),
    .RD_in      (RD_in),
    .ALU_out    (ALU_out),
    .FLAGS_in   (FLAGS_in),
    .MEM_rd     (MEM_rd),
    .MEM_wr     (MEM_wr),
    .ALU_op     (ALU_op),
    .halted     (halted),
    .fault      (fault),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {PC_out, PC_in, PC_inc, MAR_in, MDR_out, MDR_in, IR_in, RS_out, RD_out,
                RD_in, ALU_out, FLAGS_in, MEM_rd, MEM_wr, ALU_op, halted, fault, illegal};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkBit(input string name, input int idx, input int b, input logic exp);
    logic [19:0] v;
    v = seen[idx];
    checkVal(name, 32'(v[b]), 32'(exp));
  endtask

  // Reference model: each instruction expands into its cycle sequence, one row per clock.
  task automatic addRow(input logic run_v, input logic mr_v, input logic z_v,
                        input logic [19:0] strobes);
    row_t r;
    r.run = run_v;
    r.mr  = mr_v;
    r.op  = cur_op;
    r.s   = cur_s;
    r.z   = z_v;
    r.vec = strobes | (m_halt ? V_HALTED : 20'h0) | (m_fault ? V_FAULT : 20'h0) |
            (m_ill ? V_ILLEGAL : 20'h0);
    r.cnt = m_cnt;
    rows.push_back(r);
  endtask

  task automatic addAccess(input logic [19:0] strobe, input int w);
    for (int i = 0; i < w && i < MEM_WAIT_MAX; i++) addRow(rb(), 1'b0, rb(), strobe);
    if (w >= MEM_WAIT_MAX) m_fault = 1'b1;
    else addRow(rb(), 1'b1, rb(), strobe);
  endtask

  task automatic addInstr(input logic [3:0] op, input logic s, input logic z,
                          input int w1, input int w2);
    if (m_halt || m_fault) return;
    cur_op = op;
    cur_s  = s;
    addRow(rb(), rb(), rb(), V_PC_OUT | V_MAR_IN);
    addAccess(V_MEM_RD, w1);
    if (m_fault) return;
    addRow(rb(), rb(), rb(), V_MDR_OUT | V_IR_IN | V_PC_INC);
    m_cnt = m_cnt + 16'd1;
    addRow(rb(), rb(), z, 20'h0);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4:
        addRow(rb(), rb(), rb(), V_RS_OUT | V_ALU_OUT | V_RD_IN | {14'b0, op[2:0], 3'b0} |
               (s ? V_FLAGS_IN : 20'h0));
      4'h5: addRow(rb(), rb(), rb(), V_RS_OUT | V_RD_IN);
      4'h6: begin
        addRow(rb(), rb(), rb(), V_RS_OUT | V_MAR_IN);
        addAccess(V_MEM_RD, w2);
        if (!m_fault) addRow(rb(), rb(), rb(), V_MDR_OUT | V_RD_IN);
      end
      4'h7: begin
        addRow(rb(), rb(), rb(), V_RS_OUT | V_MAR_IN);
        addRow(rb(), rb(), rb(), V_RD_OUT | V_MDR_IN);
        addAccess(V_MEM_WR, w2);
      end
      4'h8: addRow(rb(), rb(), rb(), V_RS_OUT | V_PC_IN);
      4'h9: if (z) addRow(rb(), rb(), rb(), V_RS_OUT | V_PC_IN);
      4'h0: begin
      end
      4'hF: m_halt = 1'b1;
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic addStart();
    addRow(1'b1, rb(), rb(), 20'h0);
  endtask

  task automatic addTail(input int n);
    for (int i = 0; i < n; i++) addRow(rb(), rb(), rb(), 20'h0);
  endtask

  task automatic applyStimulus(input row_t r);
    run       = r.run;
    mem_ready = r.mr;
    opcode    = r.op;
    S         = r.s;
    zero_flag = r.z;
  endtask

  task automatic checkOutput(input row_t r, input int idx);
    checkVal($sformatf("row%0d strobes", idx), 32'(obs), 32'(r.vec));
    checkVal($sformatf("row%0d instr_count", idx), 32'(instr_count), 32'(r.cnt));
    seen.push_back(obs);
    seen_cnt.push_back(instr_count);
  endtask

  task automatic playRows(input int limit);
    int n;
    n = 0;
    while (rows.size() > 0 && n < limit) begin
      row_t r;
      r = rows.pop_front();
      @(posedge clk);
      #1;
      applyStimulus(r);
      @(negedge clk);
      checkOutput(r, n);
      n++;
    end
    rows.delete();
  endtask

  task automatic applyReset();
    reset     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    opcode    = 4'h0;
    S         = 1'b0;
    zero_flag = 1'b0;
    #3;
    checkVal("reset strobes", 32'(obs), 32'h0);
    checkVal("reset instr_count", 32'(instr_count), 32'h0);
    @(negedge clk);
    reset   = 1'b1;
    m_cnt   = 16'd0;
    m_ill   = 1'b0;
    m_halt  = 1'b0;
    m_fault = 1'b0;
    cur_op  = 4'h0;
    cur_s   = 1'b0;
    seen.delete();
    seen_cnt.delete();
  endtask

  initial begin
    int memrd_cycles;
    int pcin_cycles;
    logic [19:0] v;
    #1;

    // ADD with flags, zero-wait memory, then a NOP fetch
    applyReset();
    addStart();
    addInstr(4'h1, 1'b1, rb(), 0, 0);
    addInstr(4'h0, 1'b0, rb(), 0, 0);
    playRows(1000);
    checkBit("add IR_in at cycle 3", 3, 13, 1'b1);
    v = seen[5];
    checkVal("add ALU_op", 32'(v[5:3]), 32'd1);
    checkBit("add FLAGS_in", 5, 8, 1'b1);
    checkBit("add back to F0", 6, 19, 1'b1);
    checkVal("add instr_count", 32'(seen_cnt[6]), 32'd1);

    // LOAD with three wait cycles on the data read
    applyReset();
    addStart();
    addInstr(4'h6, rb(), rb(), 0, 3);
    addInstr(4'h0, 1'b0, rb(), 0, 0);
    playRows(1000);
    memrd_cycles = 0;
    for (int i = 5; i <= 10; i++) begin
      v = seen[i];
      if (v[7]) memrd_cycles++;
    end
    checkVal("load MEM_rd hold", 32'(memrd_cycles), 32'd4);
    checkBit("load RD_in before ready", 9, 10, 1'b0);
    checkBit("load RD_in after ready", 10, 10, 1'b1);

    // BRZ taken then not taken
    applyReset();
    addStart();
    addInstr(4'h9, rb(), 1'b1, 0, 0);
    addInstr(4'h9, rb(), 1'b0, 0, 0);
    addInstr(4'h0, 1'b0, rb(), 0, 0);
    playRows(1000);
    checkBit("brz taken PC_in", 5, 18, 1'b1);
    pcin_cycles = 0;
    for (int i = 6; i <= 10; i++) begin
      v = seen[i];
      if (v[18]) pcin_cycles++;
    end
    checkVal("brz not taken PC_in", 32'(pcin_cycles), 32'd0);
    checkBit("brz not taken F0", 10, 19, 1'b1);

    // Illegal opcode continues, HALT sticks and ignores run
    applyReset();
    addStart();
    addInstr(4'hA, rb(), rb(), 0, 0);
    addInstr(4'h1, 1'b0, rb(), 0, 0);
    addInstr(4'hF, rb(), rb(), 0, 0);
    addTail(6);
    playRows(1000);
    checkBit("illegal sticky", 5, 0, 1'b1);
    checkBit("halted", 14, 2, 1'b1);
    v = seen[14];
    checkVal("halt strobes quiet", 32'(v[19:3]), 32'h0);
    checkVal("halt instr_count", 32'(seen_cnt[14]), 32'd3);

    // Fetch never completes
    applyReset();
    addStart();
    addInstr(4'h0, 1'b0, rb(), 20, 0);
    addTail(4);
    playRows(1000);
    checkBit("fault last MEM_rd", 17, 7, 1'b1);
    checkBit("fault MEM_rd dropped", 18, 7, 1'b0);
    checkBit("fault flag", 18, 1, 1'b1);

    // Random program ending in HALT
    applyReset();
    addStart();
    for (int k = 0; k < 200; k++) begin
      int sel;
      logic [3:0] op;
      int w1;
      int w2;
      sel = int'($urandom_range(0, 20));
      op  = (sel < 20) ? 4'(sel % 10) : 4'($urandom_range(10, 14));
      w1  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      w2  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      addInstr(op, rb(), rb(), w1, w2);
    end
    addInstr(4'hF, rb(), rb(), 0, 0);
    addTail(8);
    playRows(100000);

    // Reset while a STORE is waiting in S2
    applyReset();
    addStart();
    addInstr(4'h7, rb(), rb(), 0, 10);
    playRows(10);
    checkBit("store MEM_wr waiting", 9, 6, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkVal("abort MEM_wr", 32'(MEM_wr), 32'd0);
    checkVal("abort strobes", 32'(obs), 32'h0);
    checkVal("abort instr_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
